// File: rtl/sc_run_ctrl.sv
// Run/halt/step sequencer, register-dump engine and retired-instruction counter.
// Build with DBG_BP_EN defined to enable the PC breakpoint compare and sticky bp_hit.
module sc_run_ctrl #(
  parameter bit BOOT_RUN = 1'b1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic [31:0]      bp_addr,
  input  logic             bp_en,
  input  logic [31:0]      cpu_pc,
  input  logic [4:0]       dbg_sel,
  input  logic [31:0]      reg_data,
  input  logic             dump_req,
  input  logic             dump_ready,
  output logic             cpu_en,
  output logic [4:0]       reg_sel,
  output logic             dump_valid,
  output logic [4:0]       dump_idx,
  output logic [31:0]      dump_data,
  output logic             halted,
  output logic             bp_hit,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_STEP, ST_DUMP} state_t;

  localparam state_t BOOT_STATE = BOOT_RUN ? ST_RUN : ST_HALT;

  state_t           state_reg, state_next;
  logic             first_reg, first_next;
  logic             bp_hit_reg, bp_hit_next;
  logic [4:0]       dump_idx_reg, dump_idx_next;
  logic [CNT_W-1:0] instret_reg;
  logic             bp_match;

`ifdef DBG_BP_EN
  // first_reg exempts the entry cycle so a resume from the breakpoint PC can execute it
  assign bp_match = (state_reg == ST_RUN) && bp_en && (cpu_pc == bp_addr) && !first_reg;
  assign bp_hit   = bp_hit_reg;
`else
  logic unused_bp;
  assign unused_bp = ^{bp_en, bp_addr, cpu_pc, first_reg, bp_hit_reg};
  assign bp_match  = 1'b0;
  assign bp_hit    = 1'b0;
`endif

  always_comb begin
    state_next    = state_reg;
    first_next    = 1'b0;
    bp_hit_next   = bp_hit_reg;
    dump_idx_next = dump_idx_reg;
    cpu_en        = 1'b0;
    case (state_reg)
      ST_RUN: begin
        cpu_en = !bp_match;
        if (bp_match) begin
          state_next  = ST_HALT;
          bp_hit_next = 1'b1;
        end else if (halt_req) begin
          state_next = ST_HALT;
        end
      end
      ST_HALT: begin
        if (dump_req) begin
          state_next = ST_DUMP;
        end else if (step_req) begin
          state_next  = ST_STEP;
          bp_hit_next = 1'b0;
        end else if (run_req) begin
          state_next  = ST_RUN;
          first_next  = 1'b1;
          bp_hit_next = 1'b0;
        end
      end
      ST_STEP: begin
        cpu_en     = 1'b1;
        state_next = ST_HALT;
      end
      ST_DUMP: begin
        // index 31 + 1 wraps to 0, leaving the engine ready for the next dump
        if (dump_ready) begin
          dump_idx_next = dump_idx_reg + 5'd1;
          if (dump_idx_reg == 5'd31) begin
            state_next = ST_HALT;
          end
        end
      end
      default: state_next = BOOT_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= BOOT_STATE;
      first_reg    <= BOOT_RUN;
      bp_hit_reg   <= 1'b0;
      dump_idx_reg <= 5'd0;
      instret_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      first_reg    <= first_next;
      bp_hit_reg   <= bp_hit_next;
      dump_idx_reg <= dump_idx_next;
      instret_reg  <= instret_reg + {{(CNT_W-1){1'b0}}, cpu_en};
    end
  end

  assign halted     = (state_reg == ST_HALT) || (state_reg == ST_DUMP);
  assign dump_valid = (state_reg == ST_DUMP);
  assign dump_idx   = dump_idx_reg;
  assign reg_sel    = dump_valid ? dump_idx_reg : dbg_sel;
  assign dump_data  = reg_data;
  assign instret    = instret_reg;

endmodule

// File: tb/tb_sc_run_ctrl.sv
// Directed bench for sc_run_ctrl: boot-run DUT (CNT_W=4) plus boot-halt DUT for stepping.
// Dump words are scoreboarded through a queue; breakpoint expectations follow DBG_BP_EN.
module tb_sc_run_ctrl;

`ifdef DBG_BP_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } dump_t;

  logic        clk, rst;
  logic        run_req, halt_req, step_req, bp_en, dump_req, dump_ready;
  logic [31:0] bp_addr, reg_data, pc;
  logic [4:0]  dbg_sel;
  logic        pc_clr;
  logic        cpu_en, dump_valid, halted, bp_hit;
  logic [4:0]  reg_sel, dump_idx;
  logic [31:0] dump_data;
  logic [3:0]  instret;

  logic        h_step_req;
  logic        h_cpu_en, h_dump_valid, h_halted, h_bp_hit;
  logic [4:0]  h_reg_sel, h_dump_idx;
  logic [31:0] h_dump_data;
  logic [3:0]  h_instret;

  int          vectors = 0;
  int          miscompares = 0;
  int          budget;
  logic [3:0]  exp_cnt;
  dump_t       sb_q[$];

  // register-file model seen by the core's select port
  function automatic logic [31:0] rf(input logic [4:0] i);
    return {8'hC3, 3'b000, i, 8'h5A, ~{3'b000, i}};
  endfunction

  assign reg_data = rf(reg_sel);

  always @(posedge clk) begin
    if (pc_clr) pc <= 32'd0;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  sc_run_ctrl #(.BOOT_RUN(1'b1), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .bp_addr(bp_addr), .bp_en(bp_en), .cpu_pc(pc), .dbg_sel(dbg_sel), .reg_data(reg_data),
    .dump_req(dump_req), .dump_ready(dump_ready), .cpu_en(cpu_en), .reg_sel(reg_sel),
    .dump_valid(dump_valid), .dump_idx(dump_idx), .dump_data(dump_data), .halted(halted),
    .bp_hit(bp_hit), .instret(instret)
  );

  sc_run_ctrl #(.BOOT_RUN(1'b0), .CNT_W(4)) u_dut_h (
    .clk(clk), .rst(rst), .run_req(1'b0), .halt_req(1'b0), .step_req(h_step_req),
    .bp_addr(32'd0), .bp_en(1'b0), .cpu_pc(32'd0), .dbg_sel(5'd0), .reg_data(32'd0),
    .dump_req(1'b0), .dump_ready(1'b0), .cpu_en(h_cpu_en), .reg_sel(h_reg_sel),
    .dump_valid(h_dump_valid), .dump_idx(h_dump_idx), .dump_data(h_dump_data),
    .halted(h_halted), .bp_hit(h_bp_hit), .instret(h_instret)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; run_req = 0; halt_req = 0; step_req = 0; bp_en = 0; dump_req = 0;
    dump_ready = 0; bp_addr = 32'h0000_0010; dbg_sel = 5'd0; pc_clr = 1'b1;
    h_step_req = 0; exp_cnt = 4'd0;
    #1 rst = 1'b0;
    #1;
    chk("rst_cpu_en", 32'(cpu_en), 32'd1);
    chk("rst_instret", 32'(instret), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_dump_valid", 32'(dump_valid), 32'd0);
    chk("rst_dump_idx", 32'(dump_idx), 32'd0);
    chk("rst_bp_hit", 32'(bp_hit), 32'd0);
    chk("rst_h_cpu_en", 32'(h_cpu_en), 32'd0);
    chk("rst_h_halted", 32'(h_halted), 32'd1);
    step_clk();
    rst = 1'b1;

    // free run from boot
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("boot_cpu_en", 32'(cpu_en), 32'd1);
      step_clk();
      exp_cnt++;
    end
    @(negedge clk);
    chk("boot_instret", 32'(instret), 32'(exp_cnt));
    chk("boot_halted", 32'(halted), 32'd0);
    step_clk();
    exp_cnt++;
    for (int i = 0; i < 4; i++) begin
      step_clk();
      exp_cnt++;
    end
    @(negedge clk);
    chk("wrap_15", 32'(instret), 32'd15);
    step_clk();
    exp_cnt++;
    halt_req = 1'b1;
    @(negedge clk);
    chk("wrap_0", 32'(instret), 32'd0);
    chk("halt_req_retires", 32'(cpu_en), 32'd1);
    step_clk();
    exp_cnt++;
    halt_req = 1'b0;
    @(negedge clk);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_cpu_en", 32'(cpu_en), 32'd0);
    step_clk();
    step_clk();
    @(negedge clk);
    chk("halt_instret", 32'(instret), 32'(exp_cnt));

    // breakpoint at 0x10 with PC advancing from 0
    step_clk();
    bp_en = 1'b1;
    run_req = 1'b1;
    step_clk();
    run_req = 1'b0;
    pc_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_pre_cpu_en", 32'(cpu_en), 32'd1);
      step_clk();
      exp_cnt++;
    end
    halt_req = !BP;
    @(negedge clk);
    chk("bp_gate_cpu_en", 32'(cpu_en), 32'(!BP));
    step_clk();
    halt_req = 1'b0;
    exp_cnt = exp_cnt + 4'(!BP);
    @(negedge clk);
    chk("bp_halted", 32'(halted), 32'd1);
    chk("bp_hit_set", 32'(bp_hit), 32'(BP));
    chk("bp_instret", 32'(instret), 32'(exp_cnt));
    chk("bp_cpu_en_off", 32'(cpu_en), 32'd0);

    // resume: the instruction at the breakpoint PC executes
    step_clk();
    run_req = 1'b1;
    step_clk();
    run_req = 1'b0;
    @(negedge clk);
    chk("resume_cpu_en", 32'(cpu_en), 32'd1);
    chk("resume_bp_hit_clr", 32'(bp_hit), 32'd0);
    chk("resume_halted", 32'(halted), 32'd0);
    step_clk();
    exp_cnt++;
    halt_req = 1'b1;
    @(negedge clk);
    chk("resume_next_en", 32'(cpu_en), 32'd1);
    step_clk();
    exp_cnt++;
    halt_req = 1'b0;
    bp_en = 1'b0;
    @(negedge clk);
    chk("resume_instret", 32'(instret), 32'(exp_cnt));
    chk("resume_halted_again", 32'(halted), 32'd1);

    // register select pass-through outside dump
    step_clk();
    dbg_sel = 5'd19;
    @(negedge clk);
    chk("passthru_reg_sel", 32'(reg_sel), 32'd19);
    chk("passthru_dump_valid", 32'(dump_valid), 32'd0);

    // simultaneous dump/step/run: dump wins, ready toggles 1,0,1,0...
    step_clk();
    dump_req = 1'b1; step_req = 1'b1; run_req = 1'b1;
    for (int i = 0; i < 32; i++) sb_q.push_back('{idx: 5'(i), data: rf(5'(i))});
    step_clk();
    dump_req = 1'b0; step_req = 1'b0; run_req = 1'b0;
    dump_ready = 1'b1;
    budget = 0;
    while (sb_q.size() > 0 && budget < 200) begin
      @(negedge clk);
      chk("dump_valid", 32'(dump_valid), 32'd1);
      chk("dump_cpu_en", 32'(cpu_en), 32'd0);
      chk("dump_reg_sel", 32'(reg_sel), 32'(sb_q[0].idx));
      chk("dump_idx", 32'(dump_idx), 32'(sb_q[0].idx));
      chk("dump_data", dump_data, sb_q[0].data);
      if (dump_valid && dump_ready) void'(sb_q.pop_front());
      step_clk();
      dump_ready = ~dump_ready;
      budget++;
    end
    chk("dump_words_left", 32'(sb_q.size()), 32'd0);
    dump_ready = 1'b0;
    @(negedge clk);
    chk("dump_done_halted", 32'(halted), 32'd1);
    chk("dump_done_valid", 32'(dump_valid), 32'd0);
    chk("dump_done_idx", 32'(dump_idx), 32'd0);
    chk("dump_done_instret", 32'(instret), 32'(exp_cnt));
    chk("dump_done_cpu_en", 32'(cpu_en), 32'd0);

    // single step on the boot-halted instance
    step_clk();
    h_step_req = 1'b1;
    @(negedge clk);
    chk("step_req_cycle_en", 32'(h_cpu_en), 32'd0);
    step_clk();
    h_step_req = 1'b0;
    @(negedge clk);
    chk("step_cpu_en", 32'(h_cpu_en), 32'd1);
    chk("step_halted", 32'(h_halted), 32'd0);
    step_clk();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("step_after_en", 32'(h_cpu_en), 32'd0);
      chk("step_after_halted", 32'(h_halted), 32'd1);
      step_clk();
    end
    chk("step_instret", 32'(h_instret), 32'd1);

    // reset in the middle of a dump at index 7
    dump_req = 1'b1;
    for (int i = 0; i < 32; i++) sb_q.push_back('{idx: 5'(i), data: rf(5'(i))});
    step_clk();
    dump_req = 1'b0;
    dump_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("dump2_idx", 32'(dump_idx), 32'(sb_q[0].idx));
      chk("dump2_data", dump_data, sb_q[0].data);
      if (dump_valid && dump_ready) void'(sb_q.pop_front());
      step_clk();
    end
    @(negedge clk);
    chk("pre_rst_idx", 32'(dump_idx), 32'd7);
    chk("pre_rst_valid", 32'(dump_valid), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(dump_valid), 32'd0);
    chk("mid_rst_idx", 32'(dump_idx), 32'd0);
    chk("mid_rst_cpu_en", 32'(cpu_en), 32'd1);
    chk("mid_rst_instret", 32'(instret), 32'd0);
    sb_q.delete();
    step_clk();
    rst = 1'b1;
    dump_ready = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(dump_valid), 32'd0);
    chk("post_rst_halted", 32'(halted), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sc_run_ctrl.md
# sc_run_ctrl

Run/halt/step sequencer and register-dump engine for the single-cycle RISC-V core. Sits between the board-level debug inputs and the core: drives the core's clock-enable, muxes the core's debug register-select port, and walks the register file out over a valid/ready stream while the core is halted. Also counts retired instructions.

## Interface

- `BOOT_RUN`, default 1: state after reset (1 = RUN, 0 = HALT).
- `CNT_W`, default 32: width of the retired-instruction counter.

- `clk` in 1: core clock.
- `rst` in 1: asynchronous, active-low reset.
- `run_req` in 1: request free-running execution (level, sampled each cycle).
- `halt_req` in 1: request halt.
- `step_req` in 1: request exactly one instruction from HALT.
- `bp_addr` in 32: breakpoint PC.
- `bp_en` in 1: breakpoint armed.
- `cpu_pc` in 32: core's current PC.
- `dbg_sel` in 5: external register select, passed through when not dumping.
- `reg_data` in 32: core's selected-register data (combinational RF read).
- `dump_req` in 1: start a 32-register dump.
- `dump_ready` in 1: sink accepts the current dump word.
- `cpu_en` out 1: core clock-enable; core state (PC, RF, memory writes) advances only when 1.
- `reg_sel` out 5: drives the core's register-select port.
- `dump_valid` out 1: dump word valid.
- `dump_idx` out 5: register index of the current dump word.
- `dump_data` out 32: dump word (= `reg_data`).
- `halted` out 1: state is HALT or DUMP.
- `bp_hit` out 1: sticky, set when a breakpoint stopped the core.
- `instret` out CNT_W: retired-instruction count.

## Operation

- States: RUN, HALT, STEP, DUMP. Encoding is internal.
- RUN: `cpu_en` = 1 except on breakpoint match. Exit to HALT on `halt_req` or on breakpoint match.
- Breakpoint match (only if `DBG_BP_EN` is defined): `bp_en` && `cpu_pc == bp_addr` && not the first cycle of a RUN entry.
  - `cpu_en` is driven 0 in the same cycle, combinationally, so the instruction at `bp_addr` is not executed.
  - `bp_hit` is set to 1.
  - The first-cycle exemption lets a resume from a breakpoint PC execute that instruction.
- HALT: `cpu_en` = 0. Request priority is `dump_req` > `step_req` > `run_req`.
  - `dump_req` → DUMP.
  - `step_req` → STEP.
  - `run_req` → RUN.
  - `bp_hit` is cleared on the transition to STEP or RUN.
- STEP: lasts exactly one cycle with `cpu_en` = 1, then returns to HALT. The breakpoint is ignored, and so are all requests.
- DUMP: `reg_sel` = `dump_idx` and `dump_valid` = 1.
  - A word transfers on `dump_valid && dump_ready`, and `dump_idx` then increments.
  - The transfer at index 31 returns the state to HALT and resets `dump_idx` to 0.
  - `run_req`, `step_req`, `halt_req` and `dump_req` are ignored until the dump completes.
  - `dump_data` is held stable while `dump_ready` = 0, because the core is frozen.
- Outside DUMP: `reg_sel` = `dbg_sel` and `dump_valid` = 0.
- RUN priority: `halt_req` in RUN takes effect the next cycle, so the current cycle still retires.
- `instret` increments by 1 in every cycle with `cpu_en` = 1. It wraps from all-ones to 0 and has no saturation.
- `halted` = 1 in HALT and DUMP.

## Timing

- Reset (`rst` = 0, async): outputs take these values immediately.
  - State = RUN if `BOOT_RUN` = 1, else HALT.
  - `cpu_en` follows the state.
  - `instret` = 0, `bp_hit` = 0, `dump_idx` = 0, `dump_valid` = 0.
- Release of reset is synchronous to the next `clk` rising edge.
- Reset in the middle of a dump aborts it with no further `dump_valid`.
- State transitions are registered, with one cycle latency from request to the new state.
- The `cpu_en` breakpoint gating is combinational from `cpu_pc` (zero latency).
- Dump throughput: one word per cycle while `dump_ready` = 1. A full dump takes a minimum of 32 cycles.
- `dump_data` is a combinational pass-through of `reg_data`.

## Configuration

- `DBG_BP_EN` defined: breakpoint compare logic present, `bp_hit` functional.
- Not defined: `bp_addr`/`bp_en` are ignored, no breakpoint match ever occurs, and `bp_hit` is tied to 0. All other behaviour is unchanged.

## Test plan

- Reset with `BOOT_RUN` = 1, no requests for 10 cycles → `cpu_en` = 1 throughout, `instret` = 10, `halted` = 0.
- Reset with `BOOT_RUN` = 0; pulse `step_req` 1 cycle, hold for 5 more cycles → exactly one `cpu_en` = 1 cycle (cycle after the request), `instret` = 1, `halted` returns to 1.
- `DBG_BP_EN` defined, `bp_en` = 1, `bp_addr` = 0x0000_0010, PC stepping by 4 from 0 → `cpu_en` = 0 at PC 0x10, `bp_hit` = 1, `instret` = 4. Then `run_req` → instruction at 0x10 executes, `bp_hit` clears.
- From HALT, `dump_req` with `dump_ready` toggling 1,0,1,0… → 32 transfers with `dump_idx` 0..31 in order, `reg_sel` tracks `dump_idx`, `cpu_en` stays 0, return to HALT after index 31.
- Simultaneous `dump_req` + `step_req` + `run_req` in HALT → DUMP entered, step and run are dropped.
- `instret` preloaded near wrap by running 2^CNT_W−1 cycles (CNT_W = 4 build): 15 → 0 on the next enabled cycle.
- Assert `rst` mid-dump at `dump_idx` = 7 → `dump_valid` = 0 and `dump_idx` = 0 immediately.
